// File: rtl/fetch_redirect_pkg.sv
// Shared constants and types for the fetch/redirect front end.
package fetch_redirect_pkg;

    // RV32 major opcodes that the fetch unit pre-decodes
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Common data bus fields used here
    localparam int CDB_VALID  = 36;
    localparam int CDB_TAG_HI = 35;
    localparam int CDB_TAG_LO = 32;

    // Valid bit of the predictor mispredict report
    localparam int BP_VALID = 4;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_JSTALL = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_redirect_branch_queue.sv
// Circular queue of in-flight conditional branches. Entries are tagged in
// order as issue hands back ROB tags, resolved by CDB tag match, and popped
// from the head once resolved. A tag lookup returns the alternate PC used
// for mispredict recovery.
module fetch_redirect_branch_queue
    import fetch_redirect_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [31:0] push_alt,
    input  logic        tag_valid,
    input  logic [3:0]  tag,
    input  logic        res_valid,
    input  logic [3:0]  res_tag,
    input  logic [3:0]  lk_tag,
    output logic        full,
    output logic        lk_hit,
    output logic [31:0] lk_alt
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] tagged_q, tagged_d;
    logic [DEPTH-1:0] resolved_q, resolved_d;
    logic [3:0]       tags_q [DEPTH];
    logic [3:0]       tags_d [DEPTH];
    logic [31:0]      alt_q [DEPTH];
    logic [31:0]      alt_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;

    logic [PW-1:0]    scan_idx;
    logic             tag_done;
    logic             pop;
    logic             push_ok;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign pop     = valid_q[head_q] && resolved_q[head_q];
    assign push_ok = push && (!full || pop);

    // Tag CAM lookup for mispredict recovery
    always_comb begin
        lk_hit = 1'b0;
        lk_alt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && tagged_q[i] && (tags_q[i] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_alt = alt_q[i];
            end
        end
    end

    // Next-state: clear, tag-on-return, CAM resolve, pop then push
    always_comb begin
        valid_d    = valid_q;
        tagged_d   = tagged_q;
        resolved_d = resolved_q;
        tags_d     = tags_q;
        alt_d      = alt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        scan_idx   = '0;
        tag_done   = 1'b0;
        if (clear) begin
            valid_d    = '0;
            tagged_d   = '0;
            resolved_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            // oldest untagged entry, scanning from the head
            if (tag_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    scan_idx = head_q + PW'(i);
                    if (!tag_done && valid_q[scan_idx] && !tagged_q[scan_idx]) begin
                        tagged_d[scan_idx] = 1'b1;
                        tags_d[scan_idx]   = tag;
                        tag_done           = 1'b1;
                    end
                end
            end
            if (res_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && tagged_q[i] && (tags_q[i] == res_tag)) begin
                        resolved_d[i] = 1'b1;
                    end
                end
            end
            // pop before push so a full queue can do both in one cycle
            if (pop) begin
                valid_d[head_q]    = 1'b0;
                tagged_d[head_q]   = 1'b0;
                resolved_d[head_q] = 1'b0;
                head_d             = head_q + PW'(1);
            end
            if (push_ok) begin
                valid_d[tail_q]    = 1'b1;
                tagged_d[tail_q]   = 1'b0;
                resolved_d[tail_q] = 1'b0;
                alt_d[tail_q]      = push_alt;
                tail_d             = tail_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
        end
    end

    // Queue storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            tagged_q   <= '0;
            resolved_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tags_q[i] <= '0;
                alt_q[i]  <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            tagged_q   <= tagged_d;
            resolved_q <= resolved_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            tags_q     <= tags_d;
            alt_q      <= alt_d;
        end
    end

endmodule

// File: rtl/fetch_redirect.sv
// Fetch/redirect front end: one-at-a-time fetch, branch pre-decode with
// predictor query, in-flight branch tracking and mispredict redirect.
//
// state  | meaning
// FETCH  | request outstanding at pc (if_req=1)
// HOLD   | fetched instruction held in output register for issue
// JSTALL | JALR accepted, waiting for its resolved target
// DRAIN  | redirected while a request was outstanding; drop its response
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_valid,
    input  logic [31:0] if_data,
    output logic [2:0]  bp_index,
    input  logic        bp_taken,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_pred,
    output logic [2:0]  inst_btype,
    input  logic        br_tag_valid,
    input  logic [3:0]  br_tag,
    input  logic [73:0] cdb,
    input  logic [4:0]  bp_tag,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    output logic        flush
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        started_q, started_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_pred_q, inst_pred_d;
    logic        is_br_q, is_br_d;
    logic        is_jalr_q, is_jalr_d;
    logic [31:0] alt_q, alt_d;
    logic        flush_q, flush_d;

    logic [6:0]  opcode;
    logic [31:0] imm_b, imm_j;
    logic [31:0] pc_plus4, br_target, jal_target;
    logic        bq_full, lk_hit;
    logic [31:0] lk_alt;
    logic        mispredict, accept, push, req_outstanding;
    logic        unused_cdb;

    assign unused_cdb = ^{cdb[73:CDB_VALID+1], cdb[CDB_TAG_LO-1:0]};

    assign opcode     = if_data[6:0];
    assign imm_b      = {{19{if_data[31]}}, if_data[31], if_data[7],
                         if_data[30:25], if_data[11:8], 1'b0};
    assign imm_j      = {{11{if_data[31]}}, if_data[31], if_data[19:12],
                         if_data[20], if_data[30:21], 1'b0};
    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = pc_q + imm_b;
    assign jal_target = pc_q + imm_j;

    // if_req stays low until the first cycle out of reset
    assign if_req     = started_q && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
    assign if_addr    = started_q ? pc_q : 32'h0;
    assign bp_index   = if_addr[4:2];
    assign inst_valid = (state_q == ST_HOLD) && !(is_br_q && bq_full);
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;
    assign inst_pred  = inst_pred_q;
    assign inst_btype = inst_pc_q[4:2];
    assign flush      = flush_q;

    assign mispredict      = bp_tag[BP_VALID] && lk_hit;
    assign accept          = inst_valid && inst_ready;
    assign push            = accept && is_br_q && !mispredict;
    assign req_outstanding = ((started_q && (state_q == ST_FETCH)) || (state_q == ST_DRAIN))
                             && !if_valid;

    fetch_redirect_branch_queue #(
        .DEPTH(BQ_DEPTH)
    ) u_bq (
        .clk      (clk),
        .rst      (rst),
        .clear    (mispredict),
        .push     (push),
        .push_alt (alt_q),
        .tag_valid(br_tag_valid && !mispredict),
        .tag      (br_tag),
        .res_valid(cdb[CDB_VALID] && !mispredict),
        .res_tag  (cdb[CDB_TAG_HI:CDB_TAG_LO]),
        .lk_tag   (bp_tag[3:0]),
        .full     (bq_full),
        .lk_hit   (lk_hit),
        .lk_alt   (lk_alt)
    );

    // Next-state, pre-decode and redirect; mispredict overrides everything
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        started_d   = 1'b1;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        inst_pred_d = inst_pred_q;
        is_br_d     = is_br_q;
        is_jalr_d   = is_jalr_q;
        alt_d       = alt_q;
        flush_d     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (started_q && if_valid) begin
                    inst_data_d = if_data;
                    inst_pc_d   = pc_q;
                    inst_pred_d = 1'b0;
                    is_br_d     = 1'b0;
                    is_jalr_d   = 1'b0;
                    alt_d       = pc_plus4;
                    pc_d        = pc_plus4;
                    state_d     = ST_HOLD;
                    case (opcode)
                        OP_BRANCH: begin
                            is_br_d     = 1'b1;
                            inst_pred_d = bp_taken;
                            pc_d        = bp_taken ? br_target : pc_plus4;
                            alt_d       = bp_taken ? pc_plus4 : br_target;
                        end
                        OP_JAL: begin
                            inst_pred_d = 1'b1;
                            pc_d        = jal_target;
                        end
                        OP_JALR: begin
                            is_jalr_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = is_jalr_q ? ST_JSTALL : ST_FETCH;
                end
            end
            ST_JSTALL: begin
                if (jalr_valid) begin
                    pc_d    = jalr_target;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (if_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
        if (mispredict) begin
            pc_d    = lk_alt;
            flush_d = 1'b1;
            state_d = req_outstanding ? ST_DRAIN : ST_FETCH;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            started_q   <= 1'b0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
            inst_pred_q <= 1'b0;
            is_br_q     <= 1'b0;
            is_jalr_q   <= 1'b0;
            alt_q       <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            started_q   <= started_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
            inst_pred_q <= inst_pred_d;
            is_br_q     <= is_br_d;
            is_jalr_q   <= is_jalr_d;
            alt_q       <= alt_d;
            flush_q     <= flush_d;
        end
    end

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: straight-line fetch, predicted branch,
// mispredict recovery (idle and with a request outstanding), queue full,
// JAL/JALR and mid-run reset.
module tb_fetch_redirect;

    localparam logic [31:0] ADDI    = 32'h0000_0013;
    localparam logic [31:0] BEQ_P32 = 32'h0200_0063;  // beq x0,x0,+0x20
    localparam logic [31:0] JAL_M24 = 32'hFE9F_F06F;  // jal x0,-0x18
    localparam logic [31:0] JALR_X1 = 32'h0000_8067;  // jalr x0,0(x1)

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_data;
    logic [2:0]  bp_index;
    logic        bp_taken;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_pred;
    logic [2:0]  inst_btype;
    logic        br_tag_valid;
    logic [3:0]  br_tag;
    logic [73:0] cdb;
    logic [4:0]  bp_tag;
    logic        jalr_valid;
    logic [31:0] jalr_target;
    logic        flush;

    int checks = 0;
    int errors = 0;

    fetch_redirect #(
        .RESET_PC(32'h0),
        .BQ_DEPTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_valid    (if_valid),
        .if_data     (if_data),
        .bp_index    (bp_index),
        .bp_taken    (bp_taken),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_pred   (inst_pred),
        .inst_btype  (inst_btype),
        .br_tag_valid(br_tag_valid),
        .br_tag      (br_tag),
        .cdb         (cdb),
        .bp_tag      (bp_tag),
        .jalr_valid  (jalr_valid),
        .jalr_target (jalr_target),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic respond(input logic [31:0] d, input logic taken);
        if_valid = 1'b1;
        if_data  = d;
        bp_taken = taken;
        tick();
        if_valid = 1'b0;
        if_data  = '0;
        bp_taken = 1'b0;
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic tag_branch(input logic [3:0] t);
        br_tag_valid = 1'b1;
        br_tag       = t;
        tick();
        br_tag_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_valid = 0; if_data = 0; bp_taken = 0; inst_ready = 0;
        br_tag_valid = 0; br_tag = 0; cdb = '0; bp_tag = '0;
        jalr_valid = 0; jalr_target = 0;
        repeat (3) tick();

        chk("rst_if_req", 32'(if_req), 0);
        chk("rst_if_addr", if_addr, 0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_pred", 32'(inst_pred), 0);
        chk("rst_inst_btype", 32'(inst_btype), 0);
        chk("rst_flush", 32'(flush), 0);

        rst = 1'b0;
        tick();
        chk("req_after_rst", 32'(if_req), 1);

        // straight-line ADDI stream at 0, 4, 8, 0xC
        for (int i = 0; i < 4; i++) begin
            chk("seq_if_addr", if_addr, 32'(4 * i));
            chk("seq_if_req", 32'(if_req), 1);
            respond(ADDI, 1'b0);
            chk("seq_inst_valid", 32'(inst_valid), 1);
            chk("seq_inst_pc", inst_pc, 32'(4 * i));
            chk("seq_inst_data", inst_data, ADDI);
            chk("seq_req_low", 32'(if_req), 0);
            chk("seq_flush", 32'(flush), 0);
            accept();
        end

        // predicted-taken BEQ at 0x10
        chk("br_if_addr", if_addr, 32'h10);
        chk("br_bp_index", 32'(bp_index), 4);
        respond(BEQ_P32, 1'b1);
        chk("br_inst_pred", 32'(inst_pred), 1);
        chk("br_inst_btype", 32'(inst_btype), 4);
        accept();
        chk("br_next_addr", if_addr, 32'h30);
        tag_branch(4'd5);

        // mispredict while holding the next instruction
        respond(ADDI, 1'b0);
        chk("hold_0x30", 32'(inst_valid), 1);
        bp_tag = 5'b10101;
        tick();
        bp_tag = '0;
        chk("mp_flush", 32'(flush), 1);
        chk("mp_if_addr", if_addr, 32'h14);
        chk("mp_inst_valid", 32'(inst_valid), 0);
        tick();
        chk("mp_flush_one", 32'(flush), 0);
        // queue now empty: the same report must be ignored
        bp_tag = 5'b10101;
        tick();
        bp_tag = '0;
        tick();
        chk("nomatch_flush", 32'(flush), 0);
        chk("nomatch_addr", if_addr, 32'h14);

        // not-taken BEQ at 0x14 (alt 0x34), then mispredict during fetch
        respond(BEQ_P32, 1'b0);
        chk("nt_pred", 32'(inst_pred), 0);
        chk("nt_btype", 32'(inst_btype), 5);
        accept();
        chk("nt_next", if_addr, 32'h18);
        tag_branch(4'd7);
        bp_tag = 5'b10111;
        tick();
        bp_tag = '0;
        chk("drain_flush", 32'(flush), 1);
        chk("drain_req", 32'(if_req), 1);
        respond(ADDI, 1'b0);
        chk("drain_discard", 32'(inst_valid), 0);
        chk("drain_flush_off", 32'(flush), 0);
        chk("drain_addr", if_addr, 32'h34);
        chk("drain_req_again", 32'(if_req), 1);

        // fill the queue with 8 unresolved branches, tags 1..8
        for (int i = 0; i < 8; i++) begin
            chk("fill_addr", if_addr, 32'h34 + 32'(4 * i));
            respond(BEQ_P32, 1'b0);
            chk("fill_valid", 32'(inst_valid), 1);
            accept();
            tag_branch(4'(i + 1));
        end
        chk("full_addr", if_addr, 32'h54);
        respond(BEQ_P32, 1'b0);
        chk("full_stall", 32'(inst_valid), 0);
        tick();
        chk("full_stall2", 32'(inst_valid), 0);
        cdb = '0;
        cdb[36] = 1'b1;
        cdb[35:32] = 4'd1;
        tick();
        cdb = '0;
        chk("full_resolved", 32'(inst_valid), 0);
        tick();
        chk("full_popped", 32'(inst_valid), 1);
        chk("full_pc", inst_pc, 32'h54);
        accept();

        // JAL back to 0x40, then JALR stall
        chk("jal_addr", if_addr, 32'h58);
        respond(JAL_M24, 1'b0);
        chk("jal_pred", 32'(inst_pred), 1);
        chk("jal_valid", 32'(inst_valid), 1);
        accept();
        chk("jal_target", if_addr, 32'h40);
        respond(JALR_X1, 1'b0);
        chk("jalr_pred", 32'(inst_pred), 0);
        accept();
        chk("jalr_stall", 32'(if_req), 0);
        tick();
        chk("jalr_stall2", 32'(if_req), 0);
        jalr_valid  = 1'b1;
        jalr_target = 32'h100;
        tick();
        jalr_valid = 1'b0;
        chk("jalr_req", 32'(if_req), 1);
        chk("jalr_addr", if_addr, 32'h100);
        chk("jalr_flush", 32'(flush), 0);

        // reset mid-run; a stale response right after reset is ignored
        rst = 1'b1;
        tick();
        chk("rst2_req", 32'(if_req), 0);
        chk("rst2_addr", if_addr, 0);
        rst = 1'b0;
        respond(ADDI, 1'b0);
        chk("rst2_ignore", 32'(inst_valid), 0);
        chk("rst2_req_up", 32'(if_req), 1);
        chk("rst2_addr0", if_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
